// File: rtl/day01_repeat_finder.sv
// rtl/day01_repeat_finder.sv - first-repeated running sum / single-pass total search engine
module day01_repeat_finder #(
   parameter int DATA_W    = 32,
   parameter int SUM_W     = 64,
   parameter int DEPTH     = 973,
   parameter int ADDR_W    = 16,
   parameter int MAX_STEPS = 1 << 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   output logic              rd_en_a,
   output logic [ADDR_W-1:0] rd_addr_a,
   input  logic [DATA_W-1:0] rd_data_a,
   output logic              rd_en_b,
   output logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] rd_data_b,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [SUM_W-1:0]  result,
   output logic [31:0]       steps
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      OUTER_RD  = 3'd1,
      OUTER_ACC = 3'd2,
      SCAN_CMP  = 3'd3,
      SCAN_ACC  = 3'd4,
      DONE      = 3'd5
   } state_t;

   // Address of the last delta; the next address after it is 0.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [31:0]       DEPTH_W   = 32'(DEPTH);
   localparam logic [31:0]       MAX_W     = 32'(MAX_STEPS);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [SUM_W-1:0]  s_out_q, s_out_d;
   logic [SUM_W-1:0]  s_in_q, s_in_d;
   logic [31:0]       k_q, k_d;
   logic [31:0]       j_q, j_d;
   logic [ADDR_W-1:0] k_addr_q, k_addr_d;
   logic [ADDR_W-1:0] j_addr_q, j_addr_d;
   logic              found_q, found_d;
   logic [SUM_W-1:0]  result_q, result_d;
   logic [31:0]       steps_q, steps_d;

   logic [SUM_W-1:0]  delta_a, delta_b;
   logic [SUM_W-1:0]  s_out_sum;
   logic [31:0]       k_inc;
   logic [ADDR_W-1:0] k_addr_inc, j_addr_inc;
   logic              sums_equal, scan_end;

   // Sign-extended deltas and the per-step helper values.
   assign delta_a    = SUM_W'($signed(rd_data_a));
   assign delta_b    = SUM_W'($signed(rd_data_b));
   assign s_out_sum  = s_out_q + delta_a;
   assign k_inc      = k_q + 32'd1;
   assign k_addr_inc = (k_addr_q == LAST_ADDR) ? '0 : k_addr_q + 1'b1;
   assign j_addr_inc = (j_addr_q == LAST_ADDR) ? '0 : j_addr_q + 1'b1;
   assign sums_equal = (s_in_q == s_out_q);
   assign scan_end   = (j_q == k_q - 32'd1);

   // The index registers already hold k mod DEPTH and j mod DEPTH.
   assign rd_addr_a = k_addr_q;
   assign rd_addr_b = j_addr_q;

   assign busy   = (state_q != IDLE) && (state_q != DONE);
   assign done   = (state_q == DONE);
   assign found  = found_q;
   assign result = result_q;
   assign steps  = steps_q;

   // State and datapath registers; reset wins over any start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= 1'b0;
         s_out_q  <= '0;
         s_in_q   <= '0;
         k_q      <= '0;
         j_q      <= '0;
         k_addr_q <= '0;
         j_addr_q <= '0;
         found_q  <= 1'b0;
         result_q <= '0;
         steps_q  <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         s_out_q  <= s_out_d;
         s_in_q   <= s_in_d;
         k_q      <= k_d;
         j_q      <= j_d;
         k_addr_q <= k_addr_d;
         j_addr_q <= j_addr_d;
         found_q  <= found_d;
         result_q <= result_d;
         steps_q  <= steps_d;
      end
   end

   // Next-state, datapath update and read-request decode.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      s_out_d  = s_out_q;
      s_in_d   = s_in_q;
      k_d      = k_q;
      j_d      = j_q;
      k_addr_d = k_addr_q;
      j_addr_d = j_addr_q;
      found_d  = found_q;
      result_d = result_q;
      steps_d  = steps_q;
      rd_en_a  = 1'b0;
      rd_en_b  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mode_d   = mode;
               s_out_d  = '0;
               s_in_d   = '0;
               k_d      = '0;
               j_d      = '0;
               k_addr_d = '0;
               j_addr_d = '0;
               found_d  = 1'b0;
               result_d = '0;
               steps_d  = '0;
               state_d  = OUTER_RD;
            end
         end

         OUTER_RD: begin
            rd_en_a = 1'b1;
            state_d = OUTER_ACC;
         end

         OUTER_ACC: begin
            s_out_d  = s_out_sum;
            k_d      = k_inc;
            k_addr_d = k_addr_inc;
            if (!mode_q) begin
               if (k_inc == DEPTH_W) begin
                  found_d  = 1'b1;
                  result_d = s_out_sum;
                  steps_d  = k_inc;
                  state_d  = DONE;
               end else begin
                  state_d = OUTER_RD;
               end
            end else begin
               j_d      = '0;
               j_addr_d = '0;
               s_in_d   = '0;
               state_d  = SCAN_CMP;
            end
         end

         SCAN_CMP: begin
            if (sums_equal) begin
               found_d  = 1'b1;
               result_d = s_out_q;
               steps_d  = k_q;
               state_d  = DONE;
            end else if (scan_end) begin
               if (k_q == MAX_W) begin
                  found_d  = 1'b0;
                  result_d = s_out_q;
                  steps_d  = k_q;
                  state_d  = DONE;
               end else begin
                  state_d = OUTER_RD;
               end
            end else begin
               rd_en_b = 1'b1;
               state_d = SCAN_ACC;
            end
         end

         SCAN_ACC: begin
            s_in_d   = s_in_q + delta_b;
            j_d      = j_q + 32'd1;
            j_addr_d = j_addr_inc;
            state_d  = SCAN_CMP;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_day01_repeat_finder.sv
// tb/tb_day01_repeat_finder.sv - randomized self-checking bench for day01_repeat_finder
module tb_day01_repeat_finder;

   localparam int A_DEPTH = 2;
   localparam int A_MAX   = 8;
   localparam int B_DEPTH = 5;
   localparam int B_MAX   = 40;
   localparam int C_DEPTH = 4;
   localparam int C_MAX   = 32;
   localparam int BUDGET  = 5000;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic mode  = 1'b0;
   int   sel   = 0;
   int   checks   = 0;
   int   failures = 0;
   longint dq[$];

   always #5 clk = ~clk;

   logic start_a, start_b, start_c;
   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);

   // Instance A: DEPTH 2, 8-bit data and sums, step limit 8
   logic       a_en_a, a_en_b, a_busy, a_done, a_found;
   logic [1:0] a_addr_a, a_addr_b;
   logic [7:0] a_data_a, a_data_b, a_result;
   logic [31:0] a_steps;
   logic [7:0] mem_a [0:3];

   day01_repeat_finder #(.DATA_W(8), .SUM_W(8), .DEPTH(A_DEPTH), .ADDR_W(2), .MAX_STEPS(A_MAX)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode),
      .rd_en_a(a_en_a), .rd_addr_a(a_addr_a), .rd_data_a(a_data_a),
      .rd_en_b(a_en_b), .rd_addr_b(a_addr_b), .rd_data_b(a_data_b),
      .busy(a_busy), .done(a_done), .found(a_found), .result(a_result), .steps(a_steps)
   );

   // Instance B: DEPTH 5, default widths, step limit 40
   logic        b_en_a, b_en_b, b_busy, b_done, b_found;
   logic [2:0]  b_addr_a, b_addr_b;
   logic [31:0] b_data_a, b_data_b, b_steps;
   logic [63:0] b_result;
   logic [31:0] mem_b [0:7];

   day01_repeat_finder #(.DATA_W(32), .SUM_W(64), .DEPTH(B_DEPTH), .ADDR_W(3), .MAX_STEPS(B_MAX)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode),
      .rd_en_a(b_en_a), .rd_addr_a(b_addr_a), .rd_data_a(b_data_a),
      .rd_en_b(b_en_b), .rd_addr_b(b_addr_b), .rd_data_b(b_data_b),
      .busy(b_busy), .done(b_done), .found(b_found), .result(b_result), .steps(b_steps)
   );

   // Instance C: DEPTH 4, default widths, step limit 32
   logic        c_en_a, c_en_b, c_busy, c_done, c_found;
   logic [2:0]  c_addr_a, c_addr_b;
   logic [31:0] c_data_a, c_data_b, c_steps;
   logic [63:0] c_result;
   logic [31:0] mem_c [0:7];

   day01_repeat_finder #(.DATA_W(32), .SUM_W(64), .DEPTH(C_DEPTH), .ADDR_W(3), .MAX_STEPS(C_MAX)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode),
      .rd_en_a(c_en_a), .rd_addr_a(c_addr_a), .rd_data_a(c_data_a),
      .rd_en_b(c_en_b), .rd_addr_b(c_addr_b), .rd_data_b(c_data_b),
      .busy(c_busy), .done(c_done), .found(c_found), .result(c_result), .steps(c_steps)
   );

   // Synchronous memories with one cycle of read latency
   always @(posedge clk) begin
      if (a_en_a) a_data_a <= mem_a[a_addr_a];
      if (a_en_b) a_data_b <= mem_a[a_addr_b];
      if (b_en_a) b_data_a <= mem_b[b_addr_a];
      if (b_en_b) b_data_b <= mem_b[b_addr_b];
      if (c_en_a) c_data_a <= mem_c[c_addr_a];
      if (c_en_b) c_data_b <= mem_c[c_addr_b];
   end

   // Read protocol monitors: address in range, only while busy, never two cycles running
   int   viol_a = 0, viol_b = 0, viol_c = 0;
   logic pa_a = 1'b0, pb_a = 1'b0, pa_b = 1'b0, pb_b = 1'b0, pa_c = 1'b0, pb_c = 1'b0;
   always @(posedge clk) begin
      pa_a <= a_en_a; pb_a <= a_en_b;
      pa_b <= b_en_a; pb_b <= b_en_b;
      pa_c <= c_en_a; pb_c <= c_en_b;
      viol_a <= viol_a + int'(a_en_a && (int'(a_addr_a) >= A_DEPTH || !a_busy || pa_a))
                       + int'(a_en_b && (int'(a_addr_b) >= A_DEPTH || !a_busy || pb_a));
      viol_b <= viol_b + int'(b_en_a && (int'(b_addr_a) >= B_DEPTH || !b_busy || pa_b))
                       + int'(b_en_b && (int'(b_addr_b) >= B_DEPTH || !b_busy || pb_b));
      viol_c <= viol_c + int'(c_en_a && (int'(c_addr_a) >= C_DEPTH || !c_busy || pa_c))
                       + int'(c_en_b && (int'(c_addr_b) >= C_DEPTH || !c_busy || pb_c));
   end

   // View of the currently selected instance
   logic   cur_busy, cur_done, cur_found, cur_en_a, cur_en_b;
   longint cur_result;
   int     cur_steps, cur_addr_a, cur_addr_b;
   always_comb begin
      cur_busy = a_busy; cur_done = a_done; cur_found = a_found;
      cur_en_a = a_en_a; cur_en_b = a_en_b;
      cur_result = longint'($signed(a_result)); cur_steps = int'(a_steps);
      cur_addr_a = int'(a_addr_a); cur_addr_b = int'(a_addr_b);
      if (sel == 1) begin
         cur_busy = b_busy; cur_done = b_done; cur_found = b_found;
         cur_en_a = b_en_a; cur_en_b = b_en_b;
         cur_result = longint'(b_result); cur_steps = int'(b_steps);
         cur_addr_a = int'(b_addr_a); cur_addr_b = int'(b_addr_b);
      end else if (sel == 2) begin
         cur_busy = c_busy; cur_done = c_done; cur_found = c_found;
         cur_en_a = c_en_a; cur_en_b = c_en_b;
         cur_result = longint'(c_result); cur_steps = int'(c_steps);
         cur_addr_a = int'(c_addr_a); cur_addr_b = int'(c_addr_b);
      end
   end

   task automatic load(input int s);
      for (int i = 0; i < dq.size(); i++) begin
         if (s == 0) mem_a[i] = 8'(dq[i]);
         else if (s == 1) mem_b[i] = 32'(dq[i]);
         else mem_c[i] = 32'(dq[i]);
      end
   endtask

   // Reference: prefix sums searched directly against the list of earlier sums
   function automatic void model(input int depth, input int sw, input int maxs, input bit md,
                                 output bit f, output longint r, output int st, output int cyc);
      longint mask, s;
      longint hist[$];
      int m;
      mask = (sw >= 64) ? -64'sd1 : ((longint'(1) << sw) - 1);
      s = 0; cyc = 0; f = 1'b0; st = 0;
      hist.push_back(0);
      if (!md) begin
         for (int n = 0; n < depth; n++) s = (s + dq[n]) & mask;
         f = 1'b1; st = depth; cyc = 2 * depth;
      end else begin
         for (int k = 1; k <= maxs; k++) begin
            s = (s + dq[(k - 1) % depth]) & mask;
            m = -1;
            for (int j = 0; j < hist.size(); j++) if (m < 0 && hist[j] == s) m = j;
            st = k;
            if (m >= 0) begin
               f = 1'b1;
               cyc += 3 + 2 * m;
               break;
            end
            cyc += 2 * k + 1;
            hist.push_back(s);
         end
      end
      if (sw < 64 && s[sw - 1]) s = s | ~mask;
      r = s;
   endfunction

   task automatic do_run(input int s, input bit md, output bit f, output longint r,
                         output int st, output int cyc, output bit to);
      sel = s; mode = md;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      while (!cur_done && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
      end
      to = !cur_done; f = cur_found; r = cur_result; st = cur_steps;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         checks++;
         if ({cur_busy, cur_done, cur_found} !== 3'b000) begin
            failures++; $display("FAIL reset_flags[%0d] got=%b exp=000", s, {cur_busy, cur_done, cur_found});
         end
         checks++;
         if (cur_result !== 0 || cur_steps !== 0) begin
            failures++; $display("FAIL reset_result[%0d] got=%0d/%0d exp=0/0", s, cur_result, cur_steps);
         end
         checks++;
         if ({cur_en_a, cur_en_b} !== 2'b00 || cur_addr_a !== 0 || cur_addr_b !== 0) begin
            failures++; $display("FAIL reset_reads[%0d] got=%b/%0d/%0d exp=00/0/0", s, {cur_en_a, cur_en_b}, cur_addr_a, cur_addr_b);
         end
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_first_timing;
      int cyc;
      dq = {}; dq.push_back(1); dq.push_back(-1); load(0);
      sel = 0; mode = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++;
      if ({cur_busy, cur_done} !== 2'b10) begin
         failures++; $display("FAIL timing_busy_rise got=%b exp=10", {cur_busy, cur_done});
      end
      cyc = 0;
      while (!cur_done && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (cyc !== 6) begin failures++; $display("FAIL timing_done_cycle got=%0d exp=6", cyc); end
      checks++;
      if (cur_found !== 1'b1 || cur_result !== 0 || cur_steps !== 2) begin
         failures++; $display("FAIL timing_outputs got=%b/%0d/%0d exp=1/0/2", cur_found, cur_result, cur_steps);
      end
      checks++;
      if (cur_busy !== 1'b0) begin failures++; $display("FAIL timing_busy_fall got=%b exp=0", cur_busy); end
   endtask

   task automatic test_depth5;
      longint vecs [3][5] = '{'{3, 3, 4, -2, -4}, '{-6, 3, 8, 5, -6}, '{7, 7, -2, -7, -4}};
      longint want [3] = '{10, 5, 14};
      bit f, ef, to; longint r, er; int st, est, cyc, ecyc;
      for (int v = 0; v < 3; v++) begin
         dq = {};
         for (int i = 0; i < 5; i++) dq.push_back(vecs[v][i]);
         load(1);
         model(B_DEPTH, 64, B_MAX, 1'b1, ef, er, est, ecyc);
         do_run(1, 1'b1, f, r, st, cyc, to);
         checks++;
         if (to || f !== 1'b1 || r !== want[v]) begin
            failures++; $display("FAIL depth5[%0d] got=%b/%0d exp=1/%0d", v, f, r, want[v]);
         end
         checks++;
         if (st !== est || cyc !== ecyc) begin
            failures++; $display("FAIL depth5_timing[%0d] got=%0d/%0d exp=%0d/%0d", v, st, cyc, est, ecyc);
         end
      end
   endtask

   task automatic test_step_limit;
      bit f, ef, to; longint r, er; int st, est, cyc, ecyc;
      dq = {}; dq.push_back(1); dq.push_back(1); load(0);
      model(A_DEPTH, 8, A_MAX, 1'b1, ef, er, est, ecyc);
      do_run(0, 1'b1, f, r, st, cyc, to);
      checks++;
      if (to || f !== 1'b0 || r !== 8 || st !== 8) begin
         failures++; $display("FAIL step_limit got=%b/%0d/%0d exp=0/8/8", f, r, st);
      end
      checks++;
      if (cyc !== ecyc) begin failures++; $display("FAIL step_limit_cycles got=%0d exp=%0d", cyc, ecyc); end
      checks++;
      if (viol_a !== 0) begin failures++; $display("FAIL step_limit_reads got=%0d exp=0", viol_a); end
   endtask

   task automatic test_mode0;
      bit f, to; longint r; int st, cyc;
      dq = {}; dq.push_back(1); dq.push_back(-2); dq.push_back(3); dq.push_back(1); load(2);
      do_run(2, 1'b0, f, r, st, cyc, to);
      checks++;
      if (to || f !== 1'b1 || r !== 3 || st !== 4) begin
         failures++; $display("FAIL mode0 got=%b/%0d/%0d exp=1/3/4", f, r, st);
      end
      checks++;
      if (cyc !== 8) begin failures++; $display("FAIL mode0_cycles got=%0d exp=8", cyc); end
      dq = {}; dq.push_back(100); dq.push_back(100); load(0);
      do_run(0, 1'b0, f, r, st, cyc, to);
      checks++;
      if (to || f !== 1'b1 || r !== -56 || st !== 2) begin
         failures++; $display("FAIL mode0_wrap got=%b/%0d/%0d exp=1/-56/2", f, r, st);
      end
   endtask

   task automatic test_random;
      bit f, ef, to, md; longint r, er; int st, est, cyc, ecyc, s, depth, maxs;
      for (int it = 0; it < 12; it++) begin
         s = 1 + int'($urandom_range(0, 1));
         md = 1'($urandom_range(0, 1));
         depth = (s == 1) ? B_DEPTH : C_DEPTH;
         maxs = (s == 1) ? B_MAX : C_MAX;
         dq = {};
         for (int i = 0; i < depth; i++) begin
            if (md) dq.push_back(longint'(int'($urandom_range(0, 10)) - 5));
            else dq.push_back(longint'(int'($urandom)));
         end
         load(s);
         model(depth, 64, maxs, md, ef, er, est, ecyc);
         do_run(s, md, f, r, st, cyc, to);
         checks++;
         if (to || f !== ef || r !== er || st !== est || cyc !== ecyc) begin
            failures++;
            $display("FAIL random[%0d] inst=%0d mode=%0d got=%b/%0d/%0d/%0d exp=%b/%0d/%0d/%0d",
                     it, s, md, f, r, st, cyc, ef, er, est, ecyc);
         end
      end
   endtask

   task automatic test_start_while_busy;
      bit ef; longint er; int est, ecyc, cyc;
      dq = {}; dq.push_back(3); dq.push_back(3); dq.push_back(4); dq.push_back(-2); dq.push_back(-4);
      load(1);
      model(B_DEPTH, 64, B_MAX, 1'b1, ef, er, est, ecyc);
      sel = 1; mode = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0; mode = 1'b0;
      cyc = 0;
      while (!cur_done && cyc < BUDGET) begin
         start = (cyc % 3 == 1) && (cyc < 30);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; mode = 1'b1;
      checks++;
      if (cur_found !== 1'b1 || cur_result !== 10 || cyc !== ecyc) begin
         failures++; $display("FAIL start_busy got=%b/%0d/%0d exp=1/10/%0d", cur_found, cur_result, cyc, ecyc);
      end
   endtask

   task automatic test_start_in_done;
      int cyc;
      sel = 1; mode = 1'b1;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++;
      if ({cur_busy, cur_done} !== 2'b10) begin
         failures++; $display("FAIL restart_flags got=%b exp=10", {cur_busy, cur_done});
      end
      cyc = 0;
      while (!cur_done && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (cur_found !== 1'b1 || cur_result !== 10 || cur_steps !== 7) begin
         failures++; $display("FAIL restart_result got=%b/%0d/%0d exp=1/10/7", cur_found, cur_result, cur_steps);
      end
   endtask

   task automatic test_reset_mid_run;
      bit seen; int n, reads;
      sel = 1; mode = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0; n = 0;
      while (!seen && n < 200) begin @(posedge clk); #1; n++; if (cur_en_b) seen = 1'b1; end
      checks++;
      if (!seen) begin failures++; $display("FAIL midrun_scan got=%b exp=1", seen); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({cur_busy, cur_done, cur_found, cur_en_a, cur_en_b} !== 5'b00000 || cur_result !== 0 ||
          cur_steps !== 0 || cur_addr_a !== 0 || cur_addr_b !== 0) begin
         failures++;
         $display("FAIL midrun_reset got=%b/%0d/%0d/%0d/%0d exp=00000/0/0/0/0",
                  {cur_busy, cur_done, cur_found, cur_en_a, cur_en_b}, cur_result, cur_steps, cur_addr_a, cur_addr_b);
      end
      start = 1'b1;
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      reads = 0;
      for (int i = 0; i < 20; i++) begin
         reads += int'(cur_en_a) + int'(cur_en_b) + int'(cur_busy);
         @(posedge clk); #1;
      end
      checks++;
      if (reads !== 0) begin failures++; $display("FAIL midrun_quiet got=%0d exp=0", reads); end
   endtask

   task automatic test_read_protocol;
      checks++;
      if (viol_a + viol_b + viol_c !== 0) begin
         failures++; $display("FAIL read_protocol got=%0d/%0d/%0d exp=0/0/0", viol_a, viol_b, viol_c);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mem_a[i] = '0;
      for (int i = 0; i < 8; i++) begin mem_b[i] = '0; mem_c[i] = '0; end
      test_reset();
      test_first_timing();
      test_depth5();
      test_step_limit();
      test_mode0();
      test_random();
      test_start_while_busy();
      test_start_in_done();
      test_reset_mid_run();
      test_read_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
